gpio_port: RTL and testbench

Memory-mapped 8-bit GPIO peripheral between the MIPS core data bus and the board pins. It replaces the direct core-to-LED wiring with a register interface. It holds a software-written output register that drives the LEDs. It samples the input pins through a synchronizer and a per-bit debouncer, and latches rising edges into a sticky flag register that can raise an interrupt.

---
 rtl/gpio_port_if.sv | 15 +
 rtl/gpio_port.sv | 104 ++++++++++
 tb/tb_gpio_port.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gpio_port_if.sv
// Register bus between the core data port and the GPIO peripheral.
// The core drives the strobes; the peripheral answers with registered read data.
interface gpio_port_if #(
   parameter int DATA_WIDTH = 32
);
   logic [1:0]            addr;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rd_valid;

   modport master (output addr, wr_en, rd_en, wdata, input rdata, rd_valid);
   modport slave  (input addr, wr_en, rd_en, wdata, output rdata, rd_valid);
endinterface

// File: rtl/gpio_port.sv
// 8-bit memory-mapped GPIO: LED output register, synchronized and debounced
// inputs, sticky rising-edge flags with a maskable level interrupt.
module gpio_port_lane #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic deb,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          accept;

   // The count saturates at CNT_MAX because acceptance clears it on that cycle.
   assign accept = (sync[1] != deb) && (cnt == CNT_MAX);
   assign rise   = accept & sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         cnt  <= '0;
         deb  <= 1'b0;
      end else begin
         sync <= {sync[0], pin};
         if (sync[1] == deb) begin
            cnt <= '0;
         end else if (accept) begin
            deb <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module gpio_port #(
   parameter int DATA_WIDTH      = 32,
   parameter int GPIO_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   gpio_port_if.slave            bus,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  irq
);
   localparam logic [1:0] A_OUT = 2'd0, A_IN = 2'd1, A_EDGE = 2'd2, A_IRQ_EN = 2'd3;

   logic [GPIO_WIDTH-1:0] out_r, edge_r, irq_en_r;
   logic [GPIO_WIDTH-1:0] deb, rise, w1c;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_wdata;

   assign unused_wdata = ^bus.wdata[DATA_WIDTH-1:GPIO_WIDTH];

   for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_lane
      gpio_port_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
         .clk   (clk),
         .reset (reset),
         .pin   (gpio_in[i]),
         .deb   (deb[i]),
         .rise  (rise[i])
      );
   end

   assign w1c = (bus.wr_en && bus.addr == A_EDGE) ? bus.wdata[GPIO_WIDTH-1:0] : '0;

   always_comb begin
      rd_word = '0;
      case (bus.addr)
         A_OUT:    rd_word[GPIO_WIDTH-1:0] = out_r;
         A_IN:     rd_word[GPIO_WIDTH-1:0] = deb;
         A_EDGE:   rd_word[GPIO_WIDTH-1:0] = edge_r;
         default:  rd_word[GPIO_WIDTH-1:0] = irq_en_r;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_r        <= '0;
         edge_r       <= '0;
         irq_en_r     <= '0;
         bus.rdata    <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         // A new rising edge outranks a simultaneous clear of the same bit.
         edge_r       <= (edge_r & ~w1c) | rise;
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) bus.rdata <= rd_word;
         if (bus.wr_en && bus.addr == A_OUT)    out_r    <= bus.wdata[GPIO_WIDTH-1:0];
         if (bus.wr_en && bus.addr == A_IRQ_EN) irq_en_r <= bus.wdata[GPIO_WIDTH-1:0];
      end
   end

   assign gpio_out = out_r;
   assign irq      = |(edge_r & irq_en_r);
endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register map, debounce timing, edge/irq and
// reset behaviour, with hand-computed expectations.
module tb_gpio_port;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq;
   logic [31:0] rv;
   int n_chk = 0;
   int n_err = 0;

   gpio_port_if #(.DATA_WIDTH(32)) bus ();

   gpio_port #(.DATA_WIDTH(32), .GPIO_WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end just after a falling edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
      d = bus.rdata;
   endtask

   initial begin
      reset = 1'b1; gpio_in = '0;
      bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), rv);
         chk("rst_reg", rv, 32'd0);
      end
      @(negedge clk);
      chk("rd_valid_pulse", {31'd0, bus.rd_valid}, 32'd0);

      // output register, upper bits dropped
      wr(2'd0, 32'h1A5);
      chk("gpio_out_a5", {24'd0, gpio_out}, 32'hA5);
      rd(2'd0, rv);
      chk("out_read", rv, 32'h0000_00A5);

      // 10-cycle glitch must be rejected
      gpio_in[3] = 1'b1;
      repeat (10) @(negedge clk);
      gpio_in[3] = 1'b0;
      repeat (30) @(negedge clk);
      rd(2'd1, rv); chk("glitch_in", rv, 32'd0);
      rd(2'd2, rv); chk("glitch_edge", rv, 32'd0);

      // stable rise accepted exactly on the 18th edge
      gpio_in[3] = 1'b1;
      repeat (17) @(negedge clk);
      rd(2'd1, rv); chk("in_before_18", rv, 32'd0);
      rd(2'd1, rv); chk("in_at_18", rv, 32'h08);
      rd(2'd2, rv); chk("edge_set", rv, 32'h08);
      chk("irq_masked", {31'd0, irq}, 32'd0);

      // W1C, falling edge ignored
      wr(2'd2, 32'h08);
      rd(2'd2, rv); chk("edge_w1c", rv, 32'd0);
      gpio_in[3] = 1'b0;
      repeat (25) @(negedge clk);
      rd(2'd1, rv); chk("in_fall", rv, 32'd0);
      rd(2'd2, rv); chk("edge_fall_ignored", rv, 32'd0);

      // edge + irq
      wr(2'd3, 32'h08);
      chk("irq_no_edge", {31'd0, irq}, 32'd0);
      gpio_in[3] = 1'b1;
      repeat (17) @(negedge clk);
      chk("irq_before_18", {31'd0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_at_18", {31'd0, irq}, 32'd1);
      rd(2'd2, rv); chk("edge_irq", rv, 32'h08);
      wr(2'd2, 32'h08);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      rd(2'd2, rv); chk("edge_cleared", rv, 32'd0);

      // set/clear collision on bit 0: write lands on the acceptance edge
      gpio_in[0] = 1'b1;
      repeat (17) @(negedge clk);
      wr(2'd2, 32'h01);
      rd(2'd2, rv); chk("collision_set_wins", rv, 32'h01);
      chk("collision_irq_masked", {31'd0, irq}, 32'd0);
      wr(2'd2, 32'h00);
      rd(2'd2, rv); chk("w1c_zero_keeps", rv, 32'h01);
      wr(2'd2, 32'h01);
      rd(2'd2, rv); chk("w1c_bit0", rv, 32'd0);

      // simultaneous read and write at OUT
      wr(2'd0, 32'h11);
      bus.addr = 2'd0; bus.wdata = 32'h22; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      chk("rw_old_value", bus.rdata, 32'h11);
      chk("rw_gpio_out", {24'd0, gpio_out}, 32'h22);
      rd(2'd0, rv); chk("rw_new_value", rv, 32'h22);
      wr(2'd1, 32'hFF);
      chk("rdata_holds", bus.rdata, 32'h22);
      rd(2'd1, rv); chk("in_write_ignored", rv, 32'h09);
      wr(2'd3, 32'hFFFF_FF08);
      rd(2'd3, rv); chk("irq_en_upper", rv, 32'h08);

      // reset while a debounce is in progress
      gpio_in[5] = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst2_gpio_out", {24'd0, gpio_out}, 32'd0);
      chk("rst2_irq", {31'd0, irq}, 32'd0);
      repeat (17) @(negedge clk);
      rd(2'd1, rv); chk("rst2_in_before", rv, 32'd0);
      rd(2'd1, rv); chk("rst2_in_after", rv, 32'h29);
      rd(2'd2, rv); chk("rst2_edge", rv, 32'h29);
      chk("rst2_irq_masked", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
